// File: rtl/fifo_ctrl_if.sv
// Handshake/status and RAM-drive bundle between a FIFO client, fifo_ctrl and its block RAM.
// The slave modport is the FIFO controller; the master modport is its client.
interface fifo_ctrl_if #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  push;
  logic [RAM_WIDTH-1:0]  push_data;
  logic                  pop;
  logic                  err_clr;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  pop_valid;
  logic                  overflow;
  logic                  underflow;
  logic                  ram_write_allow;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic [RAM_WIDTH-1:0]  ram_write_data;
  logic                  ram_read_allow;
  logic [ADDR_WIDTH-1:0] ram_read_addr;

  modport slave (
    input  push, push_data, pop, err_clr,
    output full, empty, almost_full, count, pop_valid, overflow, underflow,
           ram_write_allow, ram_write_addr, ram_write_data,
           ram_read_allow, ram_read_addr
  );

  modport master (
    output push, push_data, pop, err_clr,
    input  full, empty, almost_full, count, pop_valid, overflow, underflow,
           ram_write_allow, ram_write_addr, ram_write_data,
           ram_read_allow, ram_read_addr
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: owns pointers, occupancy and flags, drives a
// dual-port block RAM whose registered read port returns data one cycle after a pop.
module fifo_ctrl #(
  parameter int RAM_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic     clk,
  input  logic     rst,
  fifo_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  pop_vld, ovf, udf;
  logic                  push_ok, pop_ok;

  // Flags come only from the registered count, so accept decisions never
  // see a same-cycle push (no pass-through into an empty FIFO).
  assign bus.full        = (cnt == DEPTH);
  assign bus.empty       = (cnt == '0);
  assign bus.almost_full = (cnt >= AFULL);
  assign bus.count       = cnt;
  assign bus.pop_valid   = pop_vld;
  assign bus.overflow    = ovf;
  assign bus.underflow   = udf;

  assign push_ok = bus.push & ~bus.full;
  assign pop_ok  = bus.pop & ~bus.empty;

  assign bus.ram_write_allow = push_ok;
  assign bus.ram_write_addr  = wr_ptr;
  assign bus.ram_write_data  = bus.push_data;
  assign bus.ram_read_allow  = pop_ok;
  assign bus.ram_read_addr   = rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      pop_vld <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + ADDR_WIDTH'(push_ok);
      rd_ptr  <= rd_ptr + ADDR_WIDTH'(pop_ok);
      pop_vld <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A fresh error in the clearing cycle keeps the flag set.
      ovf <= (ovf & ~bus.err_clr) | (bus.push & bus.full);
      udf <= (udf & ~bus.err_clr) | (bus.pop & bus.empty);
    end
  end
endmodule
